welcome_title_placer: RTL

- Produces the per-pixel placement signals that drive the welcome-screen title bitmap drawer: `offsetX`, `offsetY` and `InsideRectangle`.
- Owns the title rectangle's on-screen position and animates it. The title slides down from above the screen to a final position, then stays there. An optional blink is available.
- Sits between the VGA pixel counters and the title bitmap drawer, which has 1-cycle registered RGB output and a 5x scale.
- Total pixel-to-RGB latency is 2 cycles: 1 cycle here, 1 cycle in the drawer.

---
 rtl/welcome_pkg.sv | 30 +++
 rtl/rect_hit_calc.sv | 42 ++++
 rtl/welcome_title_placer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/welcome_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | welcome_pkg: shared types and geometry for the welcome screen    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package welcome_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int TITLE_SCALE    = 5;
  localparam int TITLE_BITMAP_W = 60;
  localparam int TITLE_BITMAP_H = 20;

  localparam int OBJECT_WIDTH_DEF  = TITLE_BITMAP_W * TITLE_SCALE;
  localparam int OBJECT_HEIGHT_DEF = TITLE_BITMAP_H * TITLE_SCALE;

  // Screen coordinates are unsigned; object positions may sit off-screen (signed).
  localparam int COORD_W  = 11;
  localparam int SCOORD_W = 12;

  function automatic logic signed [SCOORD_W-1:0] to_scoord(input logic [COORD_W-1:0] v);
    return $signed({1'b0, v});
  endfunction

endpackage
`default_nettype wire

// File: rtl/rect_hit_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rect_hit_calc: combinational signed hit test and pixel offsets   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rect_hit_calc
  import welcome_pkg::*;
#(
  parameter int OBJECT_WIDTH  = OBJECT_WIDTH_DEF,
  parameter int OBJECT_HEIGHT = OBJECT_HEIGHT_DEF
) (
  input  logic        [COORD_W-1:0]  i_pixelX,
  input  logic        [COORD_W-1:0]  i_pixelY,
  input  logic signed [SCOORD_W-1:0] i_topLeftX,
  input  logic signed [SCOORD_W-1:0] i_topLeftY,
  output logic                       o_hit,
  output logic        [COORD_W-1:0]  o_offsetX,
  output logic        [COORD_W-1:0]  o_offsetY
);

  localparam logic signed [SCOORD_W-1:0] c_W = SCOORD_W'(OBJECT_WIDTH);
  localparam logic signed [SCOORD_W-1:0] c_H = SCOORD_W'(OBJECT_HEIGHT);

  logic signed [SCOORD_W-1:0] w_x;
  logic signed [SCOORD_W-1:0] w_y;
  logic                       w_inX;
  logic                       w_inY;

  assign w_x = to_scoord(i_pixelX);
  assign w_y = to_scoord(i_pixelY);

  // Pixels are never negative, so a negative top edge clips naturally.
  assign w_inX = (w_x >= i_topLeftX) && (w_x < i_topLeftX + c_W);
  assign w_inY = (w_y >= i_topLeftY) && (w_y < i_topLeftY + c_H);
  assign o_hit = w_inX && w_inY;

  // Low bits of the difference suffice: the result is only kept when in range.
  assign o_offsetX = o_hit ? (i_pixelX - i_topLeftX[COORD_W-1:0]) : '0;
  assign o_offsetY = o_hit ? (i_pixelY - i_topLeftY[COORD_W-1:0]) : '0;

endmodule
`default_nettype wire

// File: rtl/welcome_title_placer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | welcome_title_placer: slides the title rectangle into place and  |
// | emits registered per-pixel placement. Option: WELCOME_BLINK_EN   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module welcome_title_placer
  import welcome_pkg::*;
#(
  parameter int OBJECT_WIDTH     = OBJECT_WIDTH_DEF,
  parameter int OBJECT_HEIGHT    = OBJECT_HEIGHT_DEF,
  parameter int FINAL_TOP_LEFT_X = 170,
  parameter int FINAL_TOP_LEFT_Y = 120,
  parameter int START_TOP_LEFT_Y = -100,
  parameter int SLIDE_STEP       = 4,
  parameter int BLINK_PERIOD     = 30
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic        [COORD_W-1:0]  pixelX,
  input  logic        [COORD_W-1:0]  pixelY,
  input  logic                       startOfFrame,
  input  logic                       showWelcome,
  input  logic                       skipAnim,
  output logic        [COORD_W-1:0]  offsetX,
  output logic        [COORD_W-1:0]  offsetY,
  output logic                       InsideRectangle,
  output logic signed [SCOORD_W-1:0] topLeftY,
  output logic                       animBusy
);

  localparam logic signed [SCOORD_W-1:0] c_FINAL_X = SCOORD_W'(FINAL_TOP_LEFT_X);
  localparam logic signed [SCOORD_W-1:0] c_FINAL_Y = SCOORD_W'(FINAL_TOP_LEFT_Y);
  localparam logic signed [SCOORD_W-1:0] c_START_Y = SCOORD_W'(START_TOP_LEFT_Y);
  localparam logic signed [SCOORD_W-1:0] c_STEP    = SCOORD_W'(SLIDE_STEP);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [SCOORD_W-1:0] r_topLeftY;
  logic signed [SCOORD_W-1:0] w_topLeftY_nxt;
  logic signed [SCOORD_W-1:0] w_stepped;
  logic                       w_visible;
  logic                       w_hit;
  logic                       w_inside;
  logic        [COORD_W-1:0]  w_offX;
  logic        [COORD_W-1:0]  w_offY;
  logic                       r_inside;
  logic        [COORD_W-1:0]  r_offX;
  logic        [COORD_W-1:0]  r_offY;
  logic                       r_animBusy;

  assign w_stepped = r_topLeftY + c_STEP;

  always_comb begin
    w_state_nxt    = r_state;
    w_topLeftY_nxt = r_topLeftY;
    if (!showWelcome) begin
      w_state_nxt    = IDLE;
      w_topLeftY_nxt = c_START_Y;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = SLIDE;
          w_topLeftY_nxt = c_START_Y;
        end
        SLIDE: begin
          if (skipAnim) begin
            w_state_nxt    = SHOW;
            w_topLeftY_nxt = c_FINAL_Y;
          end else if (startOfFrame) begin
            // Clamp on the final step so the title never overshoots.
            if (w_stepped >= c_FINAL_Y) begin
              w_state_nxt    = SHOW;
              w_topLeftY_nxt = c_FINAL_Y;
            end else begin
              w_topLeftY_nxt = w_stepped;
            end
          end
        end
        SHOW: begin
          w_state_nxt = SHOW;
        end
        default: begin
          w_state_nxt    = IDLE;
          w_topLeftY_nxt = c_START_Y;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_topLeftY <= c_START_Y;
    end else begin
      r_state    <= w_state_nxt;
      r_topLeftY <= w_topLeftY_nxt;
    end
  end

`ifdef WELCOME_BLINK_EN
  localparam int                c_CNT_W    = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_PERIOD - 1);

  logic [c_CNT_W-1:0] r_frameCnt;
  logic               r_visible;

  // Counting only while SHOW is held; any other cycle restarts the blink phase.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frameCnt <= '0;
      r_visible  <= 1'b1;
    end else if ((r_state != SHOW) || (w_state_nxt != SHOW)) begin
      r_frameCnt <= '0;
      r_visible  <= 1'b1;
    end else if (startOfFrame) begin
      if (r_frameCnt == c_CNT_LAST) begin
        r_frameCnt <= '0;
        r_visible  <= ~r_visible;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  assign w_visible = r_visible;
`else
  // Blink period has no effect here; the parameter stays for interface parity.
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_PERIOD != 0);
  assign w_visible      = 1'b1;
`endif

  rect_hit_calc #(
    .OBJECT_WIDTH (OBJECT_WIDTH),
    .OBJECT_HEIGHT(OBJECT_HEIGHT)
  ) u_hit (
    .i_pixelX  (pixelX),
    .i_pixelY  (pixelY),
    .i_topLeftX(c_FINAL_X),
    .i_topLeftY(r_topLeftY),
    .o_hit     (w_hit),
    .o_offsetX (w_offX),
    .o_offsetY (w_offY)
  );

  assign w_inside = w_hit && (r_state != IDLE) && w_visible;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_inside   <= 1'b0;
      r_offX     <= '0;
      r_offY     <= '0;
      r_animBusy <= 1'b0;
    end else begin
      r_inside   <= w_inside;
      r_offX     <= w_inside ? w_offX : '0;
      r_offY     <= w_inside ? w_offY : '0;
      // Registered from the next state so animBusy lines up with the state register.
      r_animBusy <= (w_state_nxt == SLIDE);
    end
  end

  assign InsideRectangle = r_inside;
  assign offsetX         = r_offX;
  assign offsetY         = r_offY;
  assign topLeftY        = r_topLeftY;
  assign animBusy        = r_animBusy;

endmodule
`default_nettype wire
